// File: rtl/lfp_e4m4_dot_accum_if.sv
// Product-stream and dot-product-result handshakes for lfp_e4m4_dot_accum.
// Latency: none, this is wiring only.
// Backpressure: prod_ready stalls the product stream, and sum_ready holds the result.
interface lfp_e4m4_dot_accum_if #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
);
    logic                    prod_valid;
    logic                    prod_ready;
    logic [8:0]              prod;
    logic                    prod_last;
    logic                    sum_valid;
    logic                    sum_ready;
    logic signed [ACC_W-1:0] sum;
    logic [CNT_W-1:0]        sum_cnt;
    logic                    sum_ovf;

    // Producer of products / consumer of results.
    modport master (
        output prod_valid, prod, prod_last, sum_ready,
        input  prod_ready, sum_valid, sum, sum_cnt, sum_ovf
    );

    // The accumulator itself.
    modport slave (
        input  prod_valid, prod, prod_last, sum_ready,
        output prod_ready, sum_valid, sum, sum_cnt, sum_ovf
    );
endinterface

// File: rtl/lfp_e4m4_dot_accum.sv
// Decodes E4M4 products to fixed point (11 frac bits) and sums one vector per prod_last.
// Latency: the last beat is accepted at edge T and sum_valid rises after edge T+2. Throughput is 1 beat/cycle.
// Backpressure: prod_ready is low while flushing or presenting, and the result holds until sum_ready.
// Option LFP_ACC_SAT_EN: saturating add with a sticky sum_ovf. Without it the add wraps and sum_ovf=0.
module lfp_e4m4_dot_accum #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lfp_e4m4_dot_accum_if.slave  bus
);
    typedef enum logic [1:0] {S_ACC, S_FLUSH, S_OUT} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term_r;
    logic                    term_v;
    logic [CNT_W-1:0]        cnt;
    logic                    prod_ready_r;
    logic                    sum_valid_r;

    logic [3:0]              exp_f;
    logic [3:0]              mant;
    logic [19:0]             mag;
    logic signed [ACC_W-1:0] mag_ext;
    logic signed [ACC_W-1:0] term_d;
    logic signed [ACC_W-1:0] acc_add;
    logic                    ovf_add;
    logic                    accept;

    assign exp_f  = bus.prod[7:4];
    assign mant   = bus.prod[3:0];
    assign accept = bus.prod_valid && prod_ready_r;

    // Decode E4M4 to a signed term. E==0 is zero regardless of sign.
    always_comb begin
        mag     = '0;
        mag_ext = '0;
        term_d  = '0;
        if (exp_f != 4'd0) begin
            mag     = {15'd0, 1'b1, mant} << (exp_f - 4'd1);
            mag_ext = {{(ACC_W-20){1'b0}}, mag};
            term_d  = bus.prod[8] ? -mag_ext : mag_ext;
        end
    end

`ifdef LFP_ACC_SAT_EN
    logic signed [ACC_W:0] acc_wide;

    // Add one guard bit, then clamp to the representable range on signed overflow.
    always_comb begin
        acc_wide = {acc[ACC_W-1], acc} + {term_r[ACC_W-1], term_r};
        ovf_add  = acc_wide[ACC_W] != acc_wide[ACC_W-1];
        acc_add  = acc_wide[ACC_W-1:0];
        if (ovf_add) begin
            acc_add = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    // Plain two's-complement wrap, so overflow is never flagged.
    always_comb begin
        acc_add = acc + term_r;
        ovf_add = 1'b0;
    end
`endif

    logic ovf;

    // Control FSM with the term pipeline, accumulator, beat counter and registered handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_ACC;
            acc          <= '0;
            term_r       <= '0;
            term_v       <= 1'b0;
            cnt          <= '0;
            ovf          <= 1'b0;
            prod_ready_r <= 1'b1;
            sum_valid_r  <= 1'b0;
        end else begin
            case (state)
                S_ACC: begin
                    if (term_v) begin
                        acc <= acc_add;
                        ovf <= ovf | ovf_add;
                    end
                    if (accept) begin
                        term_r <= term_d;
                        term_v <= 1'b1;
                        if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                        if (bus.prod_last) begin
                            state        <= S_FLUSH;
                            prod_ready_r <= 1'b0;
                        end
                    end else begin
                        term_v <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    // Retire the last pending term, then present on the next cycle.
                    if (term_v) begin
                        acc    <= acc_add;
                        ovf    <= ovf | ovf_add;
                        term_v <= 1'b0;
                    end else begin
                        state       <= S_OUT;
                        sum_valid_r <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (bus.sum_ready) begin
                        acc          <= '0;
                        cnt          <= '0;
                        ovf          <= 1'b0;
                        state        <= S_ACC;
                        prod_ready_r <= 1'b1;
                        sum_valid_r  <= 1'b0;
                    end
                end
                default: begin
                    state        <= S_ACC;
                    prod_ready_r <= 1'b1;
                    sum_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_r;
    assign bus.sum_valid  = sum_valid_r;
    assign bus.sum        = acc;
    assign bus.sum_cnt    = cnt;
    assign bus.sum_ovf    = ovf;
endmodule

// File: tb/tb_lfp_e4m4_dot_accum.sv
// Self-checking bench for lfp_e4m4_dot_accum. It uses a vector table with a result scoreboard,
// plus hand-written latency, backpressure, overflow and reset sequences.
module tb_lfp_e4m4_dot_accum;
    logic clk;
    logic rst;

    lfp_e4m4_dot_accum_if #(.ACC_W(32), .CNT_W(16)) ifa ();
    lfp_e4m4_dot_accum_if #(.ACC_W(24), .CNT_W(16)) ifb ();

    lfp_e4m4_dot_accum #(.ACC_W(32), .CNT_W(16)) u_dut   (.clk(clk), .rst(rst), .bus(ifa));
    lfp_e4m4_dot_accum #(.ACC_W(24), .CNT_W(16)) u_dut24 (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { longint sum; int cnt; bit ovf; } exp_t;
    exp_t q[$];

    typedef struct {
        logic [5:0][8:0] beats;
        int              n;
        longint          sum;
        int              cnt;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic longint decode(input logic [8:0] p);
        longint m;
        if (p[7:4] == 4'd0) return 0;
        m = longint'(16 + p[3:0]) <<< (p[7:4] - 1);
        return p[8] ? -m : m;
    endfunction

    // Scoreboard: compare each result at the handshake.
    always @(negedge clk) begin
        if (!rst && ifa.sum_valid && ifa.sum_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %0d expected none", $signed(ifa.sum));
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_sum", longint'($signed(ifa.sum)), e.sum);
                chk("sb_cnt", longint'(ifa.sum_cnt), longint'(e.cnt));
                chk("sb_ovf", longint'(ifa.sum_ovf), longint'(e.ovf));
            end
        end
    end

    task automatic push(input longint s, input int c);
        exp_t e;
        e.sum = s;
        e.cnt = c;
        e.ovf = 1'b0;
        q.push_back(e);
    endtask

    // Drive one beat and hold it until accepted. Returns the number of stall cycles.
    task automatic send_beat(input logic [8:0] p, input logic l, output int stalls);
        ifa.prod_valid = 1'b1;
        ifa.prod       = p;
        ifa.prod_last  = l;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (ifa.prod_ready) break;
            stalls++;
            if (stalls > 50) begin
                chk("accept_timeout", longint'(stalls), 0);
                break;
            end
        end
        @(posedge clk); #1;
        ifa.prod_valid = 1'b0;
        ifa.prod_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 50; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        if (q.size() != 0) chk("drain_timeout", longint'(q.size()), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int st_sum;
        int n;
        longint es;
        logic [8:0] b;

        // Fill the vector table.
        foreach (tbl[i]) tbl[i].beats = '0;
        tbl[0].n = 1; tbl[0].beats[0] = 9'h080; tbl[0].sum = 2048;   tbl[0].cnt = 1;
        tbl[1].n = 3; tbl[1].beats[0] = 9'h080; tbl[1].beats[1] = 9'h180;
                      tbl[1].beats[2] = 9'h0C8; tbl[1].sum = 49152;  tbl[1].cnt = 3;
        tbl[2].n = 2; tbl[2].beats[0] = 9'h100; tbl[2].beats[1] = 9'h00F;
                      tbl[2].sum = 0;      tbl[2].cnt = 2;
        tbl[3].n = 1; tbl[3].beats[0] = 9'h081; tbl[3].sum = 2176;   tbl[3].cnt = 1;
        tbl[4].n = 3; tbl[4].beats[0] = 9'h1FF; tbl[4].beats[1] = 9'h0FF;
                      tbl[4].beats[2] = 9'h011; tbl[4].sum = 17;     tbl[4].cnt = 3;
        tbl[5].n = 4; tbl[5].beats[0] = 9'h1C8; tbl[5].beats[1] = 9'h110;
                      tbl[5].beats[2] = 9'h000; tbl[5].beats[3] = 9'h090;
                      tbl[5].sum = -45072; tbl[5].cnt = 4;

        ifa.prod_valid = 0; ifa.prod = '0; ifa.prod_last = 0; ifa.sum_ready = 1;
        ifb.prod_valid = 0; ifb.prod = '0; ifb.prod_last = 0; ifb.sum_ready = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_prod_ready", longint'(ifa.prod_ready), 1);
        chk("rst_sum_valid",  longint'(ifa.sum_valid), 0);
        chk("rst_sum",        longint'($signed(ifa.sum)), 0);
        chk("rst_sum_cnt",    longint'(ifa.sum_cnt), 0);
        chk("rst_sum_ovf",    longint'(ifa.sum_ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: one beat with last. Valid rises exactly two edges after accept.
        push(2048, 1);
        send_beat(9'h080, 1'b1, st);
        @(negedge clk); chk("lat_t0_valid", longint'(ifa.sum_valid), 0);
        @(negedge clk); chk("lat_t1_valid", longint'(ifa.sum_valid), 0);
        @(negedge clk); chk("lat_t2_valid", longint'(ifa.sum_valid), 1);
        wait_drain();

        // Table-driven vectors. Beats after the first must never stall.
        for (int v = 0; v < 6; v++) begin
            push(tbl[v].sum, tbl[v].cnt);
            st_sum = 0;
            for (int k = 0; k < tbl[v].n; k++) begin
                send_beat(tbl[v].beats[k], k == tbl[v].n - 1, st);
                if (k > 0) st_sum += st;
            end
            chk("tbl_no_stall", longint'(st_sum), 0);
            wait_drain();
        end

        // Random vectors checked against the decode model.
        for (int v = 0; v < 4; v++) begin
            n  = $urandom_range(1, 6);
            es = 0;
            for (int k = 0; k < n; k++) begin
                b = 9'($urandom_range(0, 511));
                es += decode(b);
                if (k == 0) push(0, n);
                q[q.size()-1].sum = es;
                send_beat(b, k == n - 1, st);
            end
            wait_drain();
        end

        // Backpressure: the result holds and incoming beats are refused.
        ifa.sum_ready = 1'b0;
        push(2048, 1);
        send_beat(9'h080, 1'b1, st);
        for (int i = 0; i < 20 && !ifa.sum_valid; i++) @(negedge clk);
        chk("bp_valid_seen", longint'(ifa.sum_valid), 1);
        @(posedge clk); #1;
        ifa.prod_valid = 1'b1; ifa.prod = 9'h0C8; ifa.prod_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_sum_stable", longint'($signed(ifa.sum)), 2048);
            chk("bp_prod_ready", longint'(ifa.prod_ready), 0);
        end
        @(posedge clk); #1;
        push(51200, 2);
        ifa.sum_ready = 1'b1;
        @(negedge clk); chk("bp_ready_still_low", longint'(ifa.prod_ready), 0);
        @(posedge clk); #1;
        @(negedge clk); chk("bp_ready_back", longint'(ifa.prod_ready), 1);
        @(posedge clk); #1;
        send_beat(9'h080, 1'b1, st);
        chk("bp_second_no_stall", longint'(st), 0);
        wait_drain();

        // Overflow on the 24-bit instance: 17 maximum positive terms.
        for (int i = 0; i < 17; i++) begin
            ifb.prod_valid = 1'b1; ifb.prod = 9'h0FF; ifb.prod_last = (i == 16);
            @(negedge clk);
            if (i == 0 || i == 16) chk("ovf_prod_ready", longint'(ifb.prod_ready), 1);
            @(posedge clk); #1;
        end
        ifb.prod_valid = 1'b0; ifb.prod_last = 1'b0;
        for (int i = 0; i < 20 && !ifb.sum_valid; i++) @(negedge clk);
        chk("ovf_valid", longint'(ifb.sum_valid), 1);
        chk("ovf_cnt", longint'(ifb.sum_cnt), 17);
`ifdef LFP_ACC_SAT_EN
        chk("ovf_sum", longint'($signed(ifb.sum)), 8388607);
        chk("ovf_flag", longint'(ifb.sum_ovf), 1);
`else
        chk("ovf_sum", longint'($signed(ifb.sum)), -8142848);
        chk("ovf_flag", longint'(ifb.sum_ovf), 0);
`endif
        @(posedge clk); #1;
        ifb.sum_ready = 1'b1;
        @(posedge clk); #1;
        ifb.sum_ready = 1'b0;
        @(negedge clk);
        chk("ovf_released", longint'(ifb.sum_valid), 0);
        chk("ovf_cleared", longint'(ifb.sum_ovf), 0);

        // Reset mid-vector discards the partial sum.
        push(2048, 1);
        send_beat(9'h0C8, 1'b0, st);
        send_beat(9'h0C8, 1'b0, st);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", longint'(ifa.sum_valid), 0);
        chk("rst_mid_ready", longint'(ifa.prod_ready), 1);
        chk("rst_mid_cnt",   longint'(ifa.sum_cnt), 0);
        @(posedge clk); #1;
        send_beat(9'h080, 1'b1, st);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
